// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data memory between the CPU (read/write) and the VGA frame
// reader (read-only). The VGA reader normally has priority. After MAX_WAIT
// consecutive denied cycles, a pending CPU request is forced through.
// Read data returns one cycle after the grant.
//
// Optional build macro:
//   DMEM_ARB_STATS_EN - adds 32-bit grant/conflict statistics counters.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cpu_req_i/we_i       CPU request (held until granted) and write select
//   cpu_addr_i/wdata_i   CPU byte address and write data
//   cpu_gnt_o/stall_o    CPU access performed this cycle / CPU must freeze
//   cpu_rdata_o/rvalid_o CPU read data, valid the cycle after a read grant
//   vga_req_i/addr_i     VGA read request (held until granted) and address
//   vga_gnt_o            VGA read performed this cycle
//   vga_rdata_o/rvalid_o VGA read data, valid the cycle after a grant
//   mem_addr_o/wdata_o/we_o  dmem address, write data, write enable
//   mem_rdata_i          dmem read data, valid one cycle after the address
//   stat_*_o             (DMEM_ARB_STATS_EN only) CPU grants, VGA grants,
//                        cycles with both requests high
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_stall_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_rvalid_o,
    input  logic          vga_req_i,
    input  logic [AW-1:0] vga_addr_i,
    output logic          vga_gnt_o,
    output logic [DW-1:0] vga_rdata_o,
    output logic          vga_rvalid_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_cpu_gnt_o,
    output logic [31:0]   stat_vga_gnt_o,
    output logic [31:0]   stat_conflict_o
`endif
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // Tracks which requester's read is in flight. The read data for that
    // requester appears on mem_rdata_i during the following cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] vga_rdata_q, vga_rdata_d;
    logic          force_cpu;
    logic          cpu_gnt;
    logic          vga_gnt;

    always_comb begin
        force_cpu   = cpu_req_i && (wait_cnt_q == WAIT_LIMIT);
        cpu_gnt     = 1'b0;
        vga_gnt     = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        owner_d     = OWN_NONE;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;

        if (force_cpu) begin
            cpu_gnt = 1'b1;
        end else if (vga_req_i) begin
            vga_gnt = 1'b1;
        end else if (cpu_req_i) begin
            cpu_gnt = 1'b1;
        end

        if (cpu_gnt) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            owner_d     = cpu_we_i ? OWN_NONE : OWN_CPU;
        end else if (vga_gnt) begin
            mem_addr_o  = vga_addr_i;
            owner_d     = OWN_VGA;
        end

        if (cpu_gnt || !cpu_req_i) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        // The return data passes straight through in the return cycle. It is
        // then held in the owner's register until that owner's next read.
        if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_rdata_i;
        end
        if (owner_q == OWN_VGA) begin
            vga_rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= OWN_NONE;
            wait_cnt_q  <= 4'd0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

    assign cpu_gnt_o    = cpu_gnt;
    assign vga_gnt_o    = vga_gnt;
    assign cpu_stall_o  = cpu_req_i && !cpu_gnt;
    // Gated by reset so that no write can land while the system is held in reset.
    assign mem_we_o     = cpu_gnt && cpu_we_i && rst_ni;
    assign cpu_rvalid_o = (owner_q == OWN_CPU);
    assign vga_rvalid_o = (owner_q == OWN_VGA);
    assign cpu_rdata_o  = cpu_rdata_d;
    assign vga_rdata_o  = vga_rdata_d;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_q, stat_vga_q, stat_conf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_cpu_q  <= '0;
            stat_vga_q  <= '0;
            stat_conf_q <= '0;
        end else begin
            if (cpu_gnt)                stat_cpu_q  <= stat_cpu_q + 32'd1;
            if (vga_gnt)                stat_vga_q  <= stat_vga_q + 32'd1;
            if (cpu_req_i && vga_req_i) stat_conf_q <= stat_conf_q + 32'd1;
        end
    end

    assign stat_cpu_gnt_o  = stat_cpu_q;
    assign stat_vga_gnt_o  = stat_vga_q;
    assign stat_conflict_o = stat_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt, vga_rvalid;
    logic [31:0] vga_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_gnt, stat_vga_gnt, stat_conflict;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
        .vga_req_i(vga_req), .vga_addr_i(vga_addr), .vga_gnt_o(vga_gnt),
        .vga_rdata_o(vga_rdata), .vga_rvalid_o(vga_rvalid),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_gnt_o(stat_cpu_gnt), .stat_vga_gnt_o(stat_vga_gnt), .stat_conflict_o(stat_conflict)
`endif
    );

    // Synchronous-read data memory standing in for dmem (64 words).
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:2]];
    end

    function automatic logic [31:0] init_word(int i);
        return 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mem [64];
    int          denied;        // consecutive cycles the CPU has been refused
    int          pend;          // 0 none, 1 CPU read in flight, 2 VGA read in flight
    logic [31:0] pend_data;
    logic [31:0] hold_cpu, hold_vga;
    int unsigned sc, sv, sx;
    logic        m_cg, m_vg;
    // snapshots of DUT outputs at the last sample point
    logic        s_cg, s_vg, s_stall, s_we, s_crv, s_vrv;
    logic [31:0] s_crd, s_vrd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] s_sc, s_sv, s_sx;
`endif

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample one cycle on the falling edge, compare with the model, advance the model,
    // and return to just after the next rising edge.
    task automatic tick();
        logic        e_cg, e_vg, e_we;
        logic [31:0] e_addr, e_cr, e_vr;
        @(negedge clk);
        if (!rst_n) begin
            denied = 0; pend = 0; hold_cpu = 0; hold_vga = 0; sc = 0; sv = 0; sx = 0;
        end
        e_cg   = cpu_req && (denied == MAXW || !vga_req);
        e_vg   = vga_req && !e_cg;
        e_we   = e_cg && cpu_we && rst_n;
        e_addr = e_cg ? cpu_addr : (e_vg ? vga_addr : 32'd0);
        e_cr   = (pend == 1) ? pend_data : hold_cpu;
        e_vr   = (pend == 2) ? pend_data : hold_vga;

        s_cg = cpu_gnt; s_vg = vga_gnt; s_stall = cpu_stall; s_we = mem_we;
        s_crv = cpu_rvalid; s_vrv = vga_rvalid; s_crd = cpu_rdata; s_vrd = vga_rdata;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("vga_gnt", 32'(vga_gnt), 32'(e_vg));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        if (e_cg || !e_vg) chk("mem_wdata", mem_wdata, e_cg ? cpu_wdata : 32'd0);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
        chk("vga_rvalid", 32'(vga_rvalid), 32'(pend == 2));
        chk("cpu_rdata", cpu_rdata, e_cr);
        chk("vga_rdata", vga_rdata, e_vr);
`ifdef DMEM_ARB_STATS_EN
        s_sc = stat_cpu_gnt; s_sv = stat_vga_gnt; s_sx = stat_conflict;
        chk("stat_cpu_gnt", stat_cpu_gnt, sc);
        chk("stat_vga_gnt", stat_vga_gnt, sv);
        chk("stat_conflict", stat_conflict, sx);
`endif
        m_cg = e_cg;
        m_vg = e_vg;
        if (rst_n) begin
            if (pend == 1) hold_cpu = pend_data;
            if (pend == 2) hold_vga = pend_data;
            pend_data = exp_mem[e_addr[7:2]];
            pend      = (e_cg && !cpu_we) ? 1 : (e_vg ? 2 : 0);
            if (e_we) exp_mem[e_addr[7:2]] = cpu_wdata;
            if (e_cg || !cpu_req) denied = 0;
            else if (denied < MAXW) denied++;
            if (e_cg) sc++;
            if (e_vg) sv++;
            if (cpu_req && vga_req) sx++;
        end
        @(posedge clk);
        #1;
    endtask

    int stalls;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]     = init_word(i);
            exp_mem[i] = init_word(i);
        end
        denied = 0; pend = 0; pend_data = 0; hold_cpu = 0; hold_vga = 0;
        sc = 0; sv = 0; sx = 0; m_cg = 0; m_vg = 0;
        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
        @(posedge clk); #1;
        tick();
        chk("rst_cpu_rvalid", 32'(s_crv), 32'd0);
        chk("rst_cpu_rdata", s_crd, 32'd0);
        tick();
        rst_n = 1'b1;

        // CPU write then read back
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        tick();
        chk("t1_wr_gnt", 32'(s_cg), 32'd1);
        chk("t1_wr_we", 32'(s_we), 32'd1);
        chk("t1_wr_stall", 32'(s_stall), 32'd0);
        cpu_we = 0;
        tick();
        cpu_req = 0;
        tick();
        chk("t1_rvalid", 32'(s_crv), 32'd1);
        chk("t1_rdata", s_crd, 32'hDEADBEEF);

        // VGA read alone
        vga_req = 1; vga_addr = 32'h40;
        tick();
        chk("t2_gnt", 32'(s_vg), 32'd1);
        chk("t2_we", 32'(s_we), 32'd0);
        vga_req = 0;
        tick();
        chk("t2_rvalid", 32'(s_vrv), 32'd1);
        chk("t2_rdata", s_vrd, init_word(16));
        tick();
        chk("t2_rvalid_pulse", 32'(s_vrv), 32'd0);

        // Simultaneous requests: VGA wins, then CPU
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; vga_req = 1; vga_addr = 32'h44;
        tick();
        chk("t3_vga_gnt", 32'(s_vg), 32'd1);
        chk("t3_cpu_stall", 32'(s_stall), 32'd1);
        vga_req = 0;
        tick();
        chk("t3_cpu_gnt", 32'(s_cg), 32'd1);
        cpu_req = 0;
        tick();

        // Bounded starvation under continuous VGA traffic
        vga_req = 1; vga_addr = 32'h48; cpu_req = 1; cpu_addr = 32'h24;
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_cg) break;
            stalls++;
        end
        chk("t4_stall_cycles", 32'(stalls), 32'(MAXW));
        chk("t4_forced_gnt", 32'(s_cg), 32'd1);
        cpu_req = 0;
        tick();
        chk("t4_vga_resumes", 32'(s_vg), 32'd1);
        vga_req = 0;
        tick();

        // Reset during the return cycle of a VGA read
        vga_req = 1; vga_addr = 32'h4C;
        tick();
        vga_req = 0; rst_n = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h12345678;
        tick();
        chk("t5_rvalid_in_rst", 32'(s_vrv), 32'd0);
        chk("t5_we_in_rst", 32'(s_we), 32'd0);
        rst_n = 1; cpu_req = 0; cpu_we = 0;
        tick();
        chk("t5_rvalid_after", 32'(s_vrv), 32'd0);
        cpu_req = 1; vga_req = 1;
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_cg) break;
            stalls++;
        end
        chk("t5_wait_cleared", 32'(stalls), 32'(MAXW));
        cpu_req = 0; vga_req = 0;
        tick();

`ifdef DMEM_ARB_STATS_EN
        rst_n = 0;
        tick();
        rst_n = 1;
        cpu_req = 1; vga_req = 1; tick(); tick();          // 2 VGA grants, 2 conflicts
        vga_req = 0; tick();                                // CPU grant
        cpu_req = 0; vga_req = 1; tick(); tick(); tick();   // 3 VGA grants
        vga_req = 0; cpu_req = 1; tick(); tick();           // 2 CPU grants
        cpu_req = 0; tick();
        chk("t6_stat_cpu", s_sc, 32'd3);
        chk("t6_stat_vga", s_sv, 32'd5);
        chk("t6_stat_conf", s_sx, 32'd2);
`endif

        // Randomized traffic; requests are held until the model says they were granted.
        cpu_req = 0; vga_req = 0; m_cg = 0; m_vg = 0;
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req || m_cg) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 32'($urandom_range(0, 63)) << 2;
                cpu_wdata = $urandom;
            end
            if (!vga_req || m_vg) begin
                vga_req  = ($urandom_range(0, 9) < 7);
                vga_addr = 32'($urandom_range(0, 63)) << 2;
            end
            rst_n = !(n == 300);
            tick();
            if (n == 300) begin
                m_cg = 1; m_vg = 1;
            end
        end
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
